// File: rtl/alu_pipe_if.sv
// Handshake bundle between the EX-stage issue logic and alu_pipe: operands/opcode in,
// result/flags out, each side with its own valid/ready pair.
interface alu_pipe_if #(parameter int WIDTH = 32);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       F;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Y;
   logic [WIDTH-1:0] HI;
   logic             zero;
   logic             ovf;

   modport master (
      output in_valid, A, B, F, out_ready,
      input  in_ready, out_valid, Y, HI, zero, ovf
   );

   modport slave (
      input  in_valid, A, B, F, out_ready,
      output in_ready, out_valid, Y, HI, zero, ovf
   );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with iterative shift-add multiply; 1-cycle latency, WIDTH cycles for MUL.
// Backpressure: a held result stalls input acceptance; in_ready is low for the whole multiply.
module alu_pipe #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       reset,
   alu_pipe_if.slave bus
);
   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   typedef enum logic {IDLE, MUL} state_t;

   state_t state;
   state_t state_nxt;

   logic [SHW-1:0]     cnt;
   logic [WIDTH-1:0]   m_a;
   logic [WIDTH-1:0]   m_hi;
   logic [WIDTH-1:0]   m_lo;
   logic               m_neg;

   logic               acc_in;
   logic               is_mul;
   logic               mul_done;
   logic [WIDTH-1:0]   bm;
   logic [WIDTH-1:0]   sum;
   logic signed [WIDTH-1:0] sra;
   logic [WIDTH-1:0]   res;
   logic               res_ovf;
   logic [WIDTH:0]     step_sum;
   logic [WIDTH-1:0]   step_hi;
   logic [WIDTH-1:0]   step_lo;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;

   assign acc_in   = bus.in_valid && bus.in_ready;
   assign is_mul   = (bus.F[2:0] == 3'b110);
   assign mul_done = (state == MUL) && (cnt == CNT_LAST);

   always_comb begin
      bm      = bus.F[3] ? ~bus.B : bus.B;
      sum     = bus.A + bm + {{(WIDTH-1){1'b0}}, bus.F[3]};
      sra     = $signed(bus.A) >>> bus.B[SHW-1:0];
      res     = '0;
      res_ovf = 1'b0;
      case (bus.F[2:0])
         3'b000: res = bus.A & bm;
         3'b001: res = bus.A | bm;
         3'b010: begin
            res     = sum;
            res_ovf = (bus.A[WIDTH-1] == bm[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         3'b011: res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
         3'b100: res = bus.A ^ bm;
         3'b101: res = ~(bus.A | bm);
         3'b111: res = bus.F[3] ? sra : (bus.A << bus.B[SHW-1:0]);
         default: res = '0;
      endcase
   end

   // One unsigned shift-add step on the magnitudes; sign is restored after the last step.
   always_comb begin
      step_sum = {1'b0, m_hi} + (m_lo[0] ? {1'b0, m_a} : {(WIDTH+1){1'b0}});
      step_hi  = step_sum[WIDTH:1];
      step_lo  = {step_sum[0], m_lo[WIDTH-1:1]};
      prod     = {step_hi, step_lo};
      prod_fix = m_neg ? -prod : prod;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
      case (state)
         IDLE: if (acc_in && is_mul) state_nxt = MUL;
         MUL:  if (mul_done)         state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.out_valid <= 1'b0;
         bus.Y         <= '0;
         bus.HI        <= '0;
         bus.zero      <= 1'b0;
         bus.ovf       <= 1'b0;
         cnt           <= '0;
         m_a           <= '0;
         m_hi          <= '0;
         m_lo          <= '0;
         m_neg         <= 1'b0;
      end else if (acc_in) begin
         if (is_mul) begin
            // Most-negative operand negates to itself, which is its correct unsigned magnitude.
            bus.out_valid <= 1'b0;
            cnt           <= '0;
            m_a           <= (bus.F[3] && bus.A[WIDTH-1]) ? -bus.A : bus.A;
            m_lo          <= (bus.F[3] && bus.B[WIDTH-1]) ? -bus.B : bus.B;
            m_hi          <= '0;
            m_neg         <= bus.F[3] && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
         end else begin
            bus.out_valid <= 1'b1;
            bus.Y         <= res;
            bus.HI        <= '0;
            bus.zero      <= (res == '0);
            bus.ovf       <= res_ovf;
         end
      end else if (state == MUL) begin
         cnt  <= cnt + SHW'(1);
         m_hi <= step_hi;
         m_lo <= step_lo;
         if (mul_done) begin
            bus.out_valid <= 1'b1;
            bus.HI        <= prod_fix[2*WIDTH-1:WIDTH];
            bus.Y         <= prod_fix[WIDTH-1:0];
            bus.zero      <= (prod_fix == '0);
            bus.ovf       <= 1'b0;
         end
      end else if (bus.out_valid && bus.out_ready) begin
         bus.out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=32 and WIDTH=8: stimulus pushes hand-computed
// results into per-DUT queues, negedge monitors pop and compare on each output transfer.
module tb_alu_pipe;
   logic clk;
   logic reset;

   int checks;
   int errors;

   typedef struct {
      logic [31:0] y;
      logic [31:0] hi;
      logic        z;
      logic        o;
   } exp_t;

   exp_t q32[$];
   exp_t q8[$];
   exp_t e32;
   exp_t e8;

   alu_pipe_if #(.WIDTH(32)) bus ();
   alu_pipe_if #(.WIDTH(8))  bus8 ();

   alu_pipe #(.WIDTH(32)) dut   (.clk(clk), .reset(reset), .bus(bus));
   alu_pipe #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         checks++;
         if (q32.size() == 0) begin
            errors++;
            $display("FAIL out32_unexpected: got Y=%h HI=%h, required no output", bus.Y, bus.HI);
         end else begin
            e32 = q32.pop_front();
            if (bus.Y !== e32.y || bus.HI !== e32.hi || bus.zero !== e32.z || bus.ovf !== e32.o) begin
               errors++;
               $display("FAIL out32: got Y=%h HI=%h zero=%b ovf=%b, required Y=%h HI=%h zero=%b ovf=%b",
                        bus.Y, bus.HI, bus.zero, bus.ovf, e32.y, e32.hi, e32.z, e32.o);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && bus8.out_valid && bus8.out_ready) begin
         checks++;
         if (q8.size() == 0) begin
            errors++;
            $display("FAIL out8_unexpected: got Y=%h HI=%h, required no output", bus8.Y, bus8.HI);
         end else begin
            e8 = q8.pop_front();
            if ({24'd0, bus8.Y} !== e8.y || {24'd0, bus8.HI} !== e8.hi ||
                bus8.zero !== e8.z || bus8.ovf !== e8.o) begin
               errors++;
               $display("FAIL out8: got Y=%h HI=%h zero=%b ovf=%b, required Y=%h HI=%h zero=%b ovf=%b",
                        bus8.Y, bus8.HI, bus8.zero, bus8.ovf, e8.y[7:0], e8.hi[7:0], e8.z, e8.o);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                        input logic [31:0] ey, input logic [31:0] ehi, input logic eo,
                        input bit expect_out);
      int n;
      bus.A = a;
      bus.B = b;
      bus.F = f;
      bus.in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue32_timeout: got in_ready=0 for %0d cycles, required 1", n);
      end else if (expect_out) begin
         q32.push_back(exp_t'{ey, ehi, (ey == 32'd0) && (ehi == 32'd0), eo});
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                         input logic [7:0] ey, input logic [7:0] ehi, input logic eo);
      int n;
      bus8.A = a;
      bus8.B = b;
      bus8.F = f;
      bus8.in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!bus8.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus8.in_ready) begin
         checks++;
         errors++;
         $display("FAIL issue8_timeout: got in_ready=0 for %0d cycles, required 1", n);
      end else begin
         q8.push_back(exp_t'{{24'd0, ey}, {24'd0, ehi}, (ey == 8'd0) && (ehi == 8'd0), eo});
      end
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b0;
   endtask

   initial begin
      int  n;
      bit  ok;

      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.in_valid = 1'b0;  bus.A = '0;  bus.B = '0;  bus.F = '0;  bus.out_ready = 1'b1;
      bus8.in_valid = 1'b0; bus8.A = '0; bus8.B = '0; bus8.F = '0; bus8.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_y",         bus.Y,              32'd0);
      chk("rst_hi",        bus.HI,             32'd0);
      chk("rst_zero",      32'(bus.zero),      32'd0);
      chk("rst_ovf",       32'(bus.ovf),       32'd0);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      @(posedge clk);
      #1;

      // Add/sub, zero flag, and result appears one edge after acceptance.
      issue(32'd5, 32'd3, 4'b0010, 32'd8, 32'd0, 1'b0, 1'b1);
      chk("lat1_out_valid", 32'(bus.out_valid), 32'd1);
      issue(32'd5, 32'd3, 4'b1010, 32'd2, 32'd0, 1'b0, 1'b1);
      issue(32'd5, 32'd5, 4'b1010, 32'd0, 32'd0, 1'b0, 1'b1);

      // Overflow, SLT and the logic opcodes.
      issue(32'h7FFF_FFFF, 32'd1, 4'b0010, 32'h8000_0000, 32'd0, 1'b1, 1'b1);
      issue(32'd3, 32'd7, 4'b1011, 32'd1, 32'd0, 1'b0, 1'b1);
      issue(32'd7, 32'd3, 4'b1011, 32'd0, 32'd0, 1'b0, 1'b1);
      issue(32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0000, 32'h00F0_1234, 32'd0, 1'b0, 1'b1);
      issue(32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0001, 32'hFFF0_FFFF, 32'd0, 1'b0, 1'b1);
      issue(32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0100, 32'hFF00_EDCB, 32'd0, 1'b0, 1'b1);
      issue(32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0101, 32'h000F_0000, 32'd0, 1'b0, 1'b1);
      issue(32'hF0F0_1234, 32'h0FF0_FFFF, 4'b1000, 32'hF000_0000, 32'd0, 1'b0, 1'b1);

      // Unsigned multiply: latency and in_ready held low.
      issue(32'hFFFF_FFFF, 32'd2, 4'b0110, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b1);
      n = 0;
      ok = 1'b1;
      while (!bus.out_valid && n < 100) begin
         if (bus.in_ready) ok = 1'b0;
         @(posedge clk);
         #1;
         n++;
      end
      chk("mul_latency", 32'(n), 32'd32);
      chk("mul_busy_in_ready_low", 32'(ok), 32'd1);

      issue(32'hFFFF_FFFD, 32'd7, 4'b1110, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 1'b0, 1'b1);
      issue(32'h8000_0000, 32'h8000_0000, 4'b1110, 32'd0, 32'h4000_0000, 1'b0, 1'b1);
      issue(32'd0, 32'd5, 4'b0110, 32'd0, 32'd0, 1'b0, 1'b1);
      n = 0;
      while (!bus.out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;

      // Backpressure, then simultaneous output and input transfer.
      bus.out_ready = 1'b0;
      issue(32'h0000_00FF, 32'h0000_000F, 4'b0000, 32'h0000_000F, 32'd0, 1'b0, 1'b1);
      bus.A = 32'd1;
      bus.B = 32'd2;
      bus.F = 4'b0001;
      bus.in_valid = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.Y !== 32'h0000_000F) ok = 1'b0;
         @(posedge clk);
         #1;
      end
      chk("hold_stable", 32'(ok), 32'd1);
      bus.out_ready = 1'b1;
      q32.push_back(exp_t'{32'd3, 32'd0, 1'b0, 1'b0});
      @(negedge clk);
      chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("b2b_out_valid", 32'(bus.out_valid), 32'd1);
      chk("b2b_y", bus.Y, 32'd3);

      // Shifts, including amount 0.
      issue(32'h8000_0001, 32'd4, 4'b0111, 32'h0000_0010, 32'd0, 1'b0, 1'b1);
      issue(32'h8000_0001, 32'd4, 4'b1111, 32'hF800_0000, 32'd0, 1'b0, 1'b1);
      issue(32'h8000_0001, 32'd0, 4'b0111, 32'h8000_0001, 32'd0, 1'b0, 1'b1);

      // Reset in the middle of a multiply: no result may emerge.
      issue(32'h0001_2345, 32'h0000_0777, 4'b0110, 32'd0, 32'd0, 1'b0, 1'b0);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_y",         bus.Y,              32'd0);
      chk("abort_hi",        bus.HI,             32'd0);
      chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
      ok = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) ok = 1'b0;
      end
      chk("abort_no_stale", 32'(ok), 32'd1);

      // Narrow instance: overflow and the most-negative signed square.
      @(posedge clk);
      #1;
      issue8(8'h7F, 8'h01, 4'b0010, 8'h80, 8'h00, 1'b1);
      issue8(8'h80, 8'h80, 4'b1110, 8'h00, 8'h40, 1'b0);
      n = 0;
      while (!bus8.out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("mul8_latency", 32'(n), 32'd8);
      issue8(8'hFF, 8'hFF, 4'b0110, 8'h01, 8'hFE, 1'b0);
      n = 0;
      while (!bus8.out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end

      repeat (5) @(posedge clk);
      #1;
      chk("q32_drained", 32'(q32.size()), 32'd0);
      chk("q8_drained",  32'(q8.size()),  32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered successor to the datapath's 32-bit combinational ALU. It keeps the same 4-bit F control encoding and adds XOR, NOR, shifts and an iterative multi-cycle multiply. Zero and overflow flags are added, and operands and results are exchanged over valid/ready handshakes. It sits in the EX stage; the hazard unit stalls the pipeline on in_ready/out_valid.

Parameters:
- WIDTH, 32: operand and result width; must be at least 2.
- SHW, $clog2(WIDTH): derived localparam, not overridable; shift-amount width.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: A, B and F are valid this cycle.
- in_ready, output, 1: block accepts an operation this cycle.
- A, input, WIDTH: source A.
- B, input, WIDTH: source B.
- F, input, 4: operation select. F[3] is the invert/modifier bit; F[2:0] is the opcode.
- out_valid, output, 1: Y, HI, zero and ovf hold a result.
- out_ready, input, 1: consumer takes the result this cycle.
- Y, output, WIDTH: result; low half for a multiply.
- HI, output, WIDTH: multiply high half; 0 for every other operation.
- zero, output, 1: result is zero (Y==0, and HI==0 for a multiply).
- ovf, output, 1: signed overflow on ADD/SUB; 0 for every other operation.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, out_valid=0, Y=0, HI=0, zero=0, ovf=0.
  - Reset asserted mid-multiply aborts the operation; no result is produced.
- Operand path: Bm = F[3] ? ~B : B; S = A + Bm + F[3], computed at WIDTH bits.
- Opcodes (F[2:0]):
  - 000: AND, A & Bm.
  - 001: OR, A | Bm.
  - 010: ADD/SUB, S.
  - 011: SLT, zero-extended S[WIDTH-1], computed as sign of S without overflow correction.
  - 100: XOR, A ^ Bm.
  - 101: NOR, ~(A | Bm).
  - 110: MUL. F[3]=0 is unsigned; F[3]=1 is signed two's complement. The full 2·WIDTH-bit product goes to {HI,Y}.
  - 111: shift by B[SHW-1:0]. F[3]=0 is logical left; F[3]=1 is arithmetic right.
- Overflow: ovf = (A[MSB]==Bm[MSB]) && (S[MSB]!=A[MSB]), for opcode 010 only.
- Handshake rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). The ready path is combinational, with no dependence on in_valid.
  - Y, HI, zero and ovf stay stable while out_valid && !out_ready.
- Single-cycle opcodes (all except 110):
  - The result is registered on the accepting edge, and out_valid=1 after that edge (latency 1).
  - Back-to-back throughput is one operation per cycle while out_ready=1.
- States:
  - IDLE:
    - Accepting a non-MUL opcode loads the output registers and stays in IDLE.
    - Accepting MUL latches the magnitudes, the product sign (F[3] && A[MSB]^B[MSB]) and cnt=0, and goes to MUL.
    - An output transfer with no new input clears out_valid.
  - MUL:
    - One shift-add step per cycle; cnt increments each step.
    - in_ready=0 throughout.
    - When cnt==WIDTH-1, the step completes, the product is negated if the sign is set, the result is loaded into {HI,Y}, out_valid is set, and the state returns to IDLE.
    - Multiply latency from the accepting edge to out_valid is WIDTH edges.
- Boundaries:
  - Shift amount 0 passes A through unchanged.
  - Signed multiply of the most negative value by itself yields 2^(2·WIDTH-2), computed correctly through the magnitude path.
  - ADD wrap-around is silent except for ovf.
  - An output transfer and a new input transfer in the same cycle are both honoured; the new result replaces the old one, and out_valid stays 1.

Test Plan:
1. Reset, then A=5, B=3, F=0010, out_ready=1. Expect Y=8, zero=0, ovf=0, one cycle after acceptance. Then F=1010 gives Y=2; F=1010 with B=5 gives Y=0, zero=1.
2. ADD with A=0x7FFFFFFF, B=1 → Y=0x80000000, ovf=1. SLT with A=3, B=7 (F=1011) → Y=1. SLT with A=7, B=3 → Y=0.
3. MUL unsigned, A=0xFFFFFFFF, B=2 → HI=1, Y=0xFFFFFFFE, out_valid exactly 32 edges after acceptance, in_ready=0 meanwhile. MUL signed, A=-3, B=7 → {HI,Y}=-21, i.e. HI=0xFFFFFFFF, Y=0xFFFFFFEB.
4. Backpressure: hold out_ready=0 after an AND result. Expect Y stable, in_ready=0, new in_valid not accepted. Raise out_ready with in_valid=1 → both transfer in that cycle, and the next result appears on the following edge.
5. Shift: A=0x80000001, B=4, F=0111 → Y=0x00000010. F=1111 → Y=0xF8000000. B=0 → Y=A.
6. Assert reset 10 cycles into a MUL → next cycle out_valid=0, Y=0, HI=0, in_ready=1, and no stale result appears. Repeat with WIDTH=8: A=0x80, B=0x80 signed → HI=0x40, Y=0x00, after 8 edges.
